// File: rtl/axil_cmd_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
// Holds the controller state encoding and the AXI response codes.
package axil_cmd_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      RSP
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
// Used for the command master's status counters.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/axil_cmd_master.sv
// Turns single commands into AXI4-Lite write or read transactions, one at a time,
// and returns the slave's response on a separate handshake with status counters.
module axil_cmd_master
   import axil_cmd_master_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdata,
   input  logic [3:0]            cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [31:0]           rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [2:0]            M_AXI_AWPROT,
   output logic                  M_AXI_AWVALID,
   input  logic                  M_AXI_AWREADY,
   output logic [31:0]           M_AXI_WDATA,
   output logic [3:0]            M_AXI_WSTRB,
   output logic                  M_AXI_WVALID,
   input  logic                  M_AXI_WREADY,
   input  logic [1:0]            M_AXI_BRESP,
   input  logic                  M_AXI_BVALID,
   output logic                  M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [2:0]            M_AXI_ARPROT,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   input  logic [31:0]           M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY,
   output logic [CNT_WIDTH-1:0]  wr_count,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic [CNT_WIDTH-1:0]  err_count
);

   state_t                state_q, state_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic                  cmd_ready_q, awvalid_q, wvalid_q, bready_q;
   logic                  arvalid_q, rready_q, rsp_valid_q, rsp_write_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q, rsp_rdata_q;
   logic [3:0]            wstrb_q;
   logic [1:0]            rsp_resp_q;
   logic                  accept, b_hs, r_hs, rsp_hs;

   assign accept = (state_q == IDLE) && cmd_valid && cmd_ready_q;
   assign b_hs   = (state_q == WR_RESP) && M_AXI_BVALID && bready_q;
   assign r_hs   = (state_q == RD_DATA) && M_AXI_RVALID && rready_q;
   assign rsp_hs = rsp_valid_q && rsp_ready;

   always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = cmd_write ? WR : RD_ADDR;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         WR: begin
            // AW and W complete independently; leave only once both have
            if (awvalid_q && M_AXI_AWREADY) aw_done_d = 1'b1;
            if (wvalid_q && M_AXI_WREADY)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d)      state_d   = WR_RESP;
         end
         WR_RESP: if (b_hs) state_d = RSP;
         RD_ADDR: if (arvalid_q && M_AXI_ARREADY) state_d = RD_DATA;
         RD_DATA: if (r_hs) state_d = RSP;
         RSP:     if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs are registered copies of what the next state demands
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= IDLE;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
      end else begin
         state_q     <= state_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         cmd_ready_q <= (state_d == IDLE);
         awvalid_q   <= (state_d == WR) && !aw_done_d;
         wvalid_q    <= (state_d == WR) && !w_done_d;
         bready_q    <= (state_d == WR_RESP);
         arvalid_q   <= (state_d == RD_ADDR);
         rready_q    <= (state_d == RD_DATA);
         rsp_valid_q <= (state_d == RSP);
         if (b_hs) begin
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= M_AXI_BRESP;
         end else if (r_hs) begin
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= M_AXI_RDATA;
            rsp_resp_q  <= M_AXI_RRESP;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (accept) begin
         addr_q  <= cmd_addr & ~ADDR_WIDTH'(3);
         wdata_q <= cmd_wdata;
         wstrb_q <= cmd_wstrb;
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
      .clk_i(ACLK), .rst_i(ARESET), .inc_i(rsp_hs && rsp_write_q), .count_o(wr_count)
   );
   sat_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
      .clk_i(ACLK), .rst_i(ARESET), .inc_i(rsp_hs && !rsp_write_q), .count_o(rd_count)
   );
   sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
      .clk_i(ACLK), .rst_i(ARESET), .inc_i(rsp_hs && (rsp_resp_q != RESP_OKAY)),
      .count_o(err_count)
   );

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_write     = rsp_write_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a four-word register-bank slave, a table of
// directed commands, and hand-written sequences for stalls and reset.
module tb_axil_cmd_master;
   import axil_cmd_master_pkg::RESP_OKAY;
   import axil_cmd_master_pkg::RESP_SLVERR;

   logic        ACLK, ARESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
   logic [2:0]  AWPROT, ARPROT;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [3:0]  WSTRB;
   logic [1:0]  BRESP, RRESP;
   logic [15:0] wr_count, rd_count, err_count;

   axil_cmd_master #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID),
      .M_AXI_AWREADY(AWREADY), .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
      .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP),
      .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR),
      .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
      .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
      .M_AXI_RREADY(RREADY),
      .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   // Slave: 4-word bank at 0x0..0xC, SLVERR for any write at or above 0x10
   logic [31:0] bank [4];
   int          aw_wait;
   int          aw_cnt;
   logic        aw_have, w_have;
   logic [31:0] aw_addr_s, w_data_s;
   logic [3:0]  w_strb_s;

   assign AWREADY = (aw_cnt >= aw_wait) && !aw_have;
   assign WREADY  = !w_have;
   assign ARREADY = !RVALID;

   always @(posedge ACLK) begin
      if (ARESET) begin
         aw_cnt  <= 0;
         aw_have <= 1'b0;
         w_have  <= 1'b0;
         BVALID  <= 1'b0;
         BRESP   <= RESP_OKAY;
         RVALID  <= 1'b0;
         RDATA   <= '0;
         RRESP   <= RESP_OKAY;
      end else begin
         if (AWVALID && AWREADY) begin
            aw_have   <= 1'b1;
            aw_addr_s <= AWADDR;
            aw_cnt    <= 0;
         end else if (AWVALID) begin
            aw_cnt <= aw_cnt + 1;
         end
         if (WVALID && WREADY) begin
            w_have   <= 1'b1;
            w_data_s <= WDATA;
            w_strb_s <= WSTRB;
         end
         if (aw_have && w_have && !BVALID) begin
            BVALID  <= 1'b1;
            aw_have <= 1'b0;
            w_have  <= 1'b0;
            if (aw_addr_s < 32'h10) begin
               BRESP <= RESP_OKAY;
               for (int b = 0; b < 4; b++)
                  if (w_strb_s[b]) bank[aw_addr_s[3:2]][8*b +: 8] <= w_data_s[8*b +: 8];
            end else begin
               BRESP <= RESP_SLVERR;
            end
         end else if (BVALID && BREADY) begin
            BVALID <= 1'b0;
         end
         if (ARVALID && ARREADY) begin
            RVALID <= 1'b1;
            RDATA  <= (ARADDR < 32'h10) ? bank[ARADDR[3:2]] : 32'hDEAD_BEEF;
            RRESP  <= RESP_OKAY;
         end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
         end
      end
   end

   // Bus monitor
   int          awv_cycles = 0, wv_cycles = 0, b_hs_cnt = 0, rspv_cycles = 0;
   logic [31:0] last_awaddr = '0, last_araddr = '0;
   logic [2:0]  prot_seen = '0;

   always @(posedge ACLK) begin
      if (AWVALID) awv_cycles <= awv_cycles + 1;
      if (WVALID) wv_cycles <= wv_cycles + 1;
      if (BVALID && BREADY) b_hs_cnt <= b_hs_cnt + 1;
      if (rsp_valid) rspv_cycles <= rspv_cycles + 1;
      if (AWVALID && AWREADY) last_awaddr <= AWADDR;
      if (ARVALID && ARREADY) last_araddr <= ARADDR;
      if (AWVALID || ARVALID) prot_seen <= prot_seen | AWPROT | ARPROT;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out", name);
   endtask

   // Called at a negedge; returns at the negedge after the response handshake
   // (or at the first response cycle when rsp_ready is low).
   task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic [1:0] resp,
                          output logic rw);
      int n;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_wstrb = 4'hF;
      n = 0;
      while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
      if (n >= 100) timeout("cmd_ready");
      @(negedge ACLK);
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 100) begin @(negedge ACLK); n++; end
      if (n >= 100) timeout("rsp_valid");
      rdata = rsp_rdata;
      resp  = rsp_resp;
      rw    = rsp_write;
      if (rsp_ready) @(negedge ACLK);
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      logic [31:0] exp_bus;
   } vec_t;

   vec_t        vecs [10];
   logic [31:0] rd;
   logic [1:0]  rs;
   logic        rw;
   int          exp_wr, exp_rd, exp_err;
   int          a0, w0, b0, r0;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 32'h0,  32'h1,  32'h0, 2'b00, 32'h0};
      vecs[1] = '{1'b1, 32'h4,  32'h2,  32'h0, 2'b00, 32'h4};
      vecs[2] = '{1'b1, 32'h8,  32'h3,  32'h0, 2'b00, 32'h8};
      vecs[3] = '{1'b1, 32'hC,  32'h4,  32'h0, 2'b00, 32'hC};
      vecs[4] = '{1'b0, 32'h0,  32'h0,  32'h1, 2'b00, 32'h0};
      vecs[5] = '{1'b0, 32'h4,  32'h0,  32'h2, 2'b00, 32'h4};
      vecs[6] = '{1'b0, 32'h8,  32'h0,  32'h3, 2'b00, 32'h8};
      vecs[7] = '{1'b0, 32'hC,  32'h0,  32'h4, 2'b00, 32'hC};
      vecs[8] = '{1'b1, 32'h10, 32'h55, 32'h0, 2'b10, 32'h10};
      vecs[9] = '{1'b0, 32'h7,  32'h0,  32'h2, 2'b00, 32'h4};

      ARESET = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b1;
      aw_wait = 0;
      repeat (3) @(negedge ACLK);
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
      chk("rst_valids", {26'b0, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 32'h0);
      chk("rst_rsp_fields", {rsp_write, rsp_resp, rsp_rdata[28:0]}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_counters", {wr_count, rd_count} | {16'b0, err_count}, 32'h0);
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'h1);

      exp_wr = 0; exp_rd = 0; exp_err = 0;
      for (int i = 0; i < 10; i++) begin
         run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, rs, rw);
         if (vecs[i].wr) exp_wr++; else exp_rd++;
         if (vecs[i].exp_resp != RESP_OKAY) exp_err++;
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("v%0d_resp", i), {30'b0, rs}, {30'b0, vecs[i].exp_resp});
         chk($sformatf("v%0d_rsp_write", i), {31'b0, rw}, {31'b0, vecs[i].wr});
         chk($sformatf("v%0d_bus_addr", i), vecs[i].wr ? last_awaddr : last_araddr,
             vecs[i].exp_bus);
         chk($sformatf("v%0d_wr_count", i), {16'b0, wr_count}, exp_wr);
         chk($sformatf("v%0d_rd_count", i), {16'b0, rd_count}, exp_rd);
         chk($sformatf("v%0d_err_count", i), {16'b0, err_count}, exp_err);
      end
      chk("prot_zero", {29'b0, prot_seen}, 32'h0);

      // Response held off by the consumer
      rsp_ready = 1'b0;
      run_cmd(1'b0, 32'h4, 32'h0, rd, rs, rw);
      chk("hold_first_rdata", rd, 32'h2);
      for (int k = 0; k < 5; k++) begin
         @(negedge ACLK);
         chk($sformatf("hold%0d_rsp_valid", k), {31'b0, rsp_valid}, 32'h1);
         chk($sformatf("hold%0d_rdata", k), rsp_rdata, 32'h2);
         chk($sformatf("hold%0d_cmd_ready", k), {31'b0, cmd_ready}, 32'h0);
      end
      rsp_ready = 1'b1;
      @(negedge ACLK);
      exp_rd++;
      chk("hold_release_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      chk("hold_release_cmd_ready", {31'b0, cmd_ready}, 32'h1);
      chk("hold_release_rd_count", {16'b0, rd_count}, exp_rd);

      // Slow AWREADY, immediate WREADY
      aw_wait = 2;
      a0 = awv_cycles; w0 = wv_cycles; b0 = b_hs_cnt;
      run_cmd(1'b1, 32'h8, 32'h5A, rd, rs, rw);
      aw_wait = 0;
      chk("awdly_awvalid_cycles", awv_cycles - a0, 32'd3);
      chk("awdly_wvalid_cycles", wv_cycles - w0, 32'd1);
      chk("awdly_b_handshakes", b_hs_cnt - b0, 32'd1);
      chk("awdly_resp", {30'b0, rs}, 32'h0);
      run_cmd(1'b0, 32'h8, 32'h0, rd, rs, rw);
      chk("awdly_readback", rd, 32'h5A);

      // Reset in the middle of a write
      aw_wait = 20;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hC; cmd_wdata = 32'h99;
      cmd_wstrb = 4'hF;
      a0 = 0;
      while (!cmd_ready && a0 < 100) begin @(negedge ACLK); a0++; end
      if (a0 >= 100) timeout("abort_cmd_ready");
      @(negedge ACLK);
      cmd_valid = 1'b0;
      chk("abort_awvalid_up", {31'b0, AWVALID}, 32'h1);
      r0 = rspv_cycles;
      @(negedge ACLK);
      ARESET = 1'b1;
      @(negedge ACLK);
      ARESET = 1'b0;
      aw_wait = 0;
      chk("abort_valids", {26'b0, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 32'h0);
      chk("abort_counters", {wr_count, rd_count} | {16'b0, err_count}, 32'h0);
      chk("abort_cmd_ready", {31'b0, cmd_ready}, 32'h0);
      chk("abort_no_rsp", rspv_cycles - r0, 32'd0);
      run_cmd(1'b0, 32'hC, 32'h0, rd, rs, rw);
      chk("after_abort_rdata", rd, 32'h4);
      chk("after_abort_rd_count", {16'b0, rd_count}, 32'h1);
      chk("after_abort_wr_count", {16'b0, wr_count}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the AXI4-Lite address width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, the width of the status counters.
REQ-003 SHALL have a fixed data width of 32 bits and a strobe width of 4 bits.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 ACLK  in  1  clock; all logic on the rising edge.
REQ-006 ARESET  in  1  synchronous active-high reset.
REQ-007 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  byte address.
REQ-010 cmd_wdata/cmd_wstrb  in  32/4  write data and strobes.
REQ-011 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-012 rsp_write  out  1  echoes cmd_write.
REQ-013 rsp_rdata  out  32  read data; 0 for writes.
REQ-014 rsp_resp  out  2  BRESP or RRESP.
REQ-015 M_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite master channels: ADDR, PROT, VALID, READY, DATA, STRB, RESP.
REQ-016 wr_count, rd_count, err_count  out  CNT_WIDTH each  completed writes, completed reads, and responses with non-OKAY status.

Function
REQ-017 FSM states SHALL be IDLE, WR, WR_RESP, RD_ADDR, RD_DATA and RSP.
REQ-018 cmd_ready SHALL be high only in IDLE; an accepted command SHALL latch all cmd_* fields.
REQ-019 On a write accept in cycle N, the block SHALL move to WR and assert AWVALID and WVALID in cycle N+1.
REQ-020 In WR, AWVALID and WVALID SHALL each deassert independently in the cycle after their own handshake.
REQ-021 WR SHALL go to WR_RESP in the cycle after the later of the AW and W handshakes, or after both if they occur in the same cycle.
REQ-022 BREADY SHALL be high only in WR_RESP; a B handshake SHALL capture BRESP and move to RSP.
REQ-023 On a read accept, the block SHALL move to RD_ADDR with ARVALID high until the AR handshake, then to RD_DATA.
REQ-024 RREADY SHALL be high only in RD_DATA; an R handshake SHALL capture RDATA and RRESP and move to RSP.
REQ-025 A VALID SHALL never drop before its handshake, and address and data SHALL stay stable while VALID is high.
REQ-026 A READY already high before VALID SHALL complete the handshake in the first VALID cycle.
REQ-027 AWADDR and ARADDR SHALL be cmd_addr with bits [1:0] forced to 0; AWPROT and ARPROT SHALL be 3'b000.
REQ-028 In RSP, rsp_valid SHALL be high with stable fields until rsp_ready; return to IDLE is the next cycle.
REQ-029 Minimum turnaround SHALL be 5 cycles from accept to next cmd_ready, with zero-wait slave and rsp_ready tied high.
REQ-030 wr_count or rd_count SHALL increment on the response handshake; err_count SHALL also increment when resp != 2'b00.
REQ-031 All counters SHALL saturate at all-ones.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 Reset SHALL force IDLE, all VALID/READY outputs to 0, rsp_* fields to 0, counters to 0 and cmd_ready to 0 during reset.
REQ-034 Reset mid-transaction SHALL abandon the transaction without a response; the system SHALL reset the slave in the same cycles.

Structure
REQ-035 A package axil_cmd_master_pkg SHALL hold the FSM state enum and the constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
REQ-036 One sub-module, sat_counter (parameter WIDTH, inc input), SHALL be instantiated three times.

Verification
REQ-037 Writes of 0x1..0x4 to 0x0,0x4,0x8,0xC, then reads of the same addresses, against the register bank -> reads return 0x1..0x4, resp 0, wr_count=4, rd_count=4.
REQ-038 AWREADY delayed 3 cycles with WREADY immediate -> WVALID drops after 1 cycle, AWVALID holds 3, one B accepted.
REQ-039 Slave returns BRESP=2'b10 on a write to 0x10 -> rsp_resp=2, rsp_write=1, err_count=1.
REQ-040 rsp_ready held low 5 cycles after a read of 0x4 -> rsp_valid and rsp_rdata=0x2 stable, cmd_ready low throughout.
REQ-041 ARESET pulsed 1 cycle after AWVALID rises -> all VALIDs 0 next cycle, no rsp_valid, counters 0, next command completes normally.
REQ-042 cmd_addr=0x7 read -> ARADDR=0x4.
